lsu_align: RTL and testbench

- Load/store unit directly upstream of the word-organised data memory.
- Accepts CPU byte-addressed load/store requests with funct3-encoded size (BYTE, HALF_WORD, WORD, U_BYTE, U_HALF_WORD).
- Converts each request into whole-word accesses on one memory read port and the write port; the memory side always uses mode WORD.
- Does byte-lane extraction, sign/zero extension and read-modify-write merge itself, and splits accesses that cross a word boundary into two word accesses.

---
 rtl/lsu_align.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu_align.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// lsu_align: byte-addressed load/store front end for a word-organised data memory.
// Converts CPU byte/half/word requests into whole-word memory reads and writes. It
// extracts and extends load data and merges store data with read-modify-write.
// Build option: define LSU_MISALIGN_EN to split accesses that straddle a word
// boundary into two word accesses. Without it such accesses are rejected with resp_err.
module lsu_align #(
    parameter int RAM_SIZE_LOG = 8,
    parameter int ADDR_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_mode,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic [RAM_SIZE_LOG-1:0] mem_ra,
    output logic [2:0]              mem_rm,
    input  logic [31:0]             mem_rd,
    output logic                    mem_we,
    output logic [RAM_SIZE_LOG-1:0] mem_wa,
    output logic [2:0]              mem_wm,
    output logic [31:0]             mem_wd
);
    localparam logic [2:0]              MODE_WORD = 3'b010;
    localparam logic [RAM_SIZE_LOG-1:0] W_LAST    = '1;
    localparam logic [RAM_SIZE_LOG-1:0] W_ONE     = RAM_SIZE_LOG'(1);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD0, WR0, RESP} state_t;
`endif

    state_t state, state_nxt;
    logic   started;    // keeps req_ready low until the first edge after reset release
    logic   accept;
    logic   err_q;
    logic   we_q;

    logic [2:0]              mode_q;
    logic [1:0]              off_q;
    logic [RAM_SIZE_LOG-1:0] w0_q;
    logic [31:0]             wdata_q;
    logic [31:0]             buf0;
    logic [63:0]             wide;

    logic [1:0]              req_off;
    logic [RAM_SIZE_LOG-1:0] req_w0;
    logic [2:0]              req_size;
    logic                    req_err;
    logic                    req_full_wr;
`ifdef LSU_MISALIGN_EN
    logic                    req_span;
    logic                    span_q;
    logic [31:0]             buf1;
`endif

    // Access size in bytes from the low two funct3 bits
    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    // Overlay the store bytes onto the two-word window at byte offset off
    function automatic logic [63:0] merge_word(input logic [63:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [63:0] mask;
        case (sz)
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        mask       = mask << {off, 3'b000};
        merge_word = (old & ~mask) | (({32'b0, wd} << {off, 3'b000}) & mask);
    endfunction

    // Pull the addressed bytes out of the window and sign/zero extend them
    function automatic logic [31:0] extract(input logic [63:0] win, input logic [2:0] mode,
                                            input logic [1:0] off);
        logic [31:0] sh;
        sh = 32'(win >> {off, 3'b000});
        case (mode)
            3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extract = {24'b0, sh[7:0]};
            3'b101:  extract = {16'b0, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_EN
    assign wide = {buf1, buf0};
`else
    assign wide = {32'b0, buf0};
`endif

    // Decode the incoming request: word address, offset, size and rejection reasons
    always_comb begin
        req_off     = req_addr[1:0];
        req_w0      = req_addr[RAM_SIZE_LOG+1:2];
        req_size    = size_of(req_mode[1:0]);
        req_full_wr = req_we && (req_mode == MODE_WORD) && (req_off == 2'b00);
        req_err     = 1'b0;
        if (!(req_mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) req_err = 1'b1;
        if (req_we && req_mode[2]) req_err = 1'b1;
        if (req_addr[ADDR_W-1:RAM_SIZE_LOG+2] != '0) req_err = 1'b1;
`ifdef LSU_MISALIGN_EN
        req_span = ({1'b0, req_off} + req_size) > 3'd4;
        // a split access may not wrap from the last word back to word 0
        if (req_span && (req_w0 == W_LAST)) req_err = 1'b1;
`else
        if ((req_size == 3'd2 && req_off[0]) || (req_size == 3'd4 && req_off != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Control state: FSM register and the request flags that steer it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
`ifdef LSU_MISALIGN_EN
            span_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (accept) begin
                err_q  <= req_err;
                we_q   <= req_we;
`ifdef LSU_MISALIGN_EN
                span_q <= req_span;
`endif
            end
        end
    end

    // Datapath capture: latched request fields and read buffers
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q  <= req_mode;
            off_q   <= req_off;
            w0_q    <= req_w0;
            wdata_q <= req_wdata;
        end
        if (state == RD0) buf0 <= mem_rd;
`ifdef LSU_MISALIGN_EN
        if (state == RD1) buf1 <= mem_rd;
`endif
    end

    // Next-state sequencing through reads, writes and the response cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (req_err)          state_nxt = RESP;
                else if (req_full_wr) state_nxt = WR0;
                else                  state_nxt = RD0;
            end
`ifdef LSU_MISALIGN_EN
            RD0:  state_nxt = span_q ? RD1 : (we_q ? WR0 : RESP);
            RD1:  state_nxt = we_q ? WR0 : RESP;
            WR0:  state_nxt = span_q ? WR1 : RESP;
            WR1:  state_nxt = RESP;
`else
            RD0:  state_nxt = we_q ? WR0 : RESP;
            WR0:  state_nxt = RESP;
`endif
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; everything idles at zero
    always_comb begin
        req_ready  = started && (state == IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'b0;
        mem_ra     = '0;
        mem_we     = 1'b0;
        mem_wa     = '0;
        mem_wd     = 32'b0;
        mem_rm     = MODE_WORD;
        mem_wm     = MODE_WORD;
        case (state)
            RD0: mem_ra = w0_q;
            WR0: begin
                mem_we = 1'b1;
                mem_wa = w0_q;
                mem_wd = 32'(merge_word(wide, wdata_q, mode_q[1:0], off_q));
            end
`ifdef LSU_MISALIGN_EN
            RD1: mem_ra = w0_q + W_ONE;
            WR1: begin
                mem_we = 1'b1;
                mem_wa = w0_q + W_ONE;
                mem_wd = 32'(merge_word(wide, wdata_q, mode_q[1:0], off_q) >> 32);
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !we_q) resp_rdata = extract(wide, mode_q, off_q);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed checks followed by randomized
// requests compared against a byte-array reference memory.
module tb_lsu_align;
    localparam int RSL = 8;
    localparam int AW  = 32;
    localparam int NW  = 1 << RSL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [2:0]     req_mode = 3'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [31:0]    req_wdata = '0;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_err;
    logic [RSL-1:0] mem_ra;
    logic [2:0]     mem_rm;
    logic [31:0]    mem_rd;
    logic           mem_we;
    logic [RSL-1:0] mem_wa;
    logic [2:0]     mem_wm;
    logic [31:0]    mem_wd;

    logic [31:0]    mem      [NW];
    logic [31:0]    init_img [NW];
    logic           load_img = 1'b0;
    logic [7:0]     ref_bytes [NW*4];

    logic [20:0]    we_bits;
    logic [RSL-1:0] ra_seq [21];

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_align #(.RAM_SIZE_LOG(RSL), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ra(mem_ra), .mem_rm(mem_rm), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wm(mem_wm), .mem_wd(mem_wd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_ra];

    // Word memory: image load or DUT write, committed on the falling edge
    always @(negedge clk) begin
        if (load_img) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_img[i];
        end else if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] m);
        case (m[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_err(input bit we, input logic [2:0] m, input logic [31:0] a);
        int sz  = size_of(m);
        int off = int'(a % 4);
        if (!(m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        if (we && m[2]) return 1'b1;
        if (a >= 32'(NW * 4)) return 1'b1;
`ifdef LSU_MISALIGN_EN
        if ((off + sz > 4) && (a / 4 == 32'(NW - 1))) return 1'b1;
`else
        if ((int'(a) % sz) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] m, input logic [31:0] a);
        logic [31:0] v  = '0;
        int          sz = size_of(m);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_bytes[int'(a) + i];
        case (m)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic void ref_store(input logic [31:0] a, input int sz, input logic [31:0] wd);
        for (int i = 0; i < sz; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
    endfunction

    function automatic int mem_diff();
        int d = 0;
        for (int w = 0; w < NW; w++)
            if (mem[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]}) d++;
        return d;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input bit rnd);
        for (int i = 0; i < NW; i++) init_img[i] = rnd ? $urandom : 32'h0;
        init_img[0] = w0;
        init_img[1] = w1;
        init_img[2] = w2;
        for (int i = 0; i < NW; i++)
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = init_img[i][8*b +: 8];
        load_img = 1'b1;
        @(negedge clk);
        #1 load_img = 1'b0;
    endtask

    task automatic do_req(input bit we, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat, output int nwe, output int busy_rdy,
                          output logic resp_after, output logic rdy_after);
        rdata = '0; err = 1'b0; lat = 0; nwe = 0; busy_rdy = 0;
        resp_after = 1'b0; rdy_after = 1'b0; we_bits = '0;
        for (int i = 0; i < 21; i++) ra_seq[i] = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_mode = m; req_addr = a; req_wdata = wd;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            we_bits[c] = mem_we;
            ra_seq[c]  = mem_ra;
            if (mem_we) nwe++;
            if (req_ready) busy_rdy++;
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        resp_after = resp_valid;
        rdy_after  = req_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        preload(32'h44332211, 32'h88776655, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== 34'b0) begin n_fail++;
            $display("FAIL rst_resp: got %h want 0", {resp_valid, resp_err, resp_rdata}); end
        n_cmp++; if ({mem_we, mem_ra, mem_wa, mem_wd} !== '0) begin n_fail++;
            $display("FAIL rst_mem: got %h want 0", {mem_we, mem_ra, mem_wa, mem_wd}); end
        n_cmp++; if ({mem_rm, mem_wm} !== 6'b010_010) begin n_fail++;
            $display("FAIL mem_modes: got %b want 010010", {mem_rm, mem_wm}); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_loads();
        logic [2:0]  mtab [3] = '{3'b000, 3'b001, 3'b101};
        logic [31:0] atab [3] = '{32'h3, 32'h6, 32'h6};
        logic [31:0] etab [3] = '{32'h00000044, 32'hFFFF8877, 32'h00008877};
        logic [31:0] rd; logic er, ra, ry; int lat, nwe, br;
        preload(32'h44332211, 32'h88776655, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, mtab[i], atab[i], 32'h0, rd, er, lat, nwe, br, ra, ry);
            n_cmp++; if (rd !== etab[i]) begin n_fail++; $display("FAIL ld_data[%0d]: got %h want %h", i, rd, etab[i]); end
            n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL ld_lat[%0d]: got %0d want 2", i, lat); end
            n_cmp++; if ({er, nwe} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL ld_err_we[%0d]: got err=%b we=%0d want 0/0", i, er, nwe); end
        end
        do_req(1'b0, 3'b010, 32'h1, 32'h0, rd, er, lat, nwe, br, ra, ry);
`ifdef LSU_MISALIGN_EN
        n_cmp++; if (rd !== 32'h55443322) begin n_fail++; $display("FAIL lw_span_data: got %h want 55443322", rd); end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lw_span_lat: got %0d want 3", lat); end
        n_cmp++; if ({ra_seq[1], ra_seq[2]} !== {8'd0, 8'd1}) begin n_fail++;
            $display("FAIL lw_span_ra: got %0d,%0d want 0,1", ra_seq[1], ra_seq[2]); end
        n_cmp++; if (nwe !== 0) begin n_fail++; $display("FAIL lw_span_we: got %0d want 0", nwe); end
`else
        n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL lw_mis_err: got err=%b data=%h want 1/0", er, rd); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL lw_mis_lat: got %0d want 1", lat); end
`endif
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er, ra, ry; int lat, nwe, br;
        preload(32'h44332211, 32'h88776655, 32'h0, 1'b0);
        do_req(1'b1, 3'b000, 32'h5, 32'h000000AB, rd, er, lat, nwe, br, ra, ry);
        n_cmp++; if ({mem[0], mem[1]} !== {32'h44332211, 32'h8877AB55}) begin n_fail++;
            $display("FAIL sb_mem: got %h %h want 44332211 8877ab55", mem[0], mem[1]); end
        n_cmp++; if (nwe !== 1) begin n_fail++; $display("FAIL sb_we_count: got %0d want 1", nwe); end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sb_lat: got %0d want 3", lat); end
        n_cmp++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL sb_resp: got err=%b data=%h want 0/0", er, rd); end
        do_req(1'b1, 3'b010, 32'h8, 32'h12345678, rd, er, lat, nwe, br, ra, ry);
        n_cmp++; if (mem[2] !== 32'h12345678) begin n_fail++; $display("FAIL sw_mem: got %h want 12345678", mem[2]); end
        n_cmp++; if ({lat, we_bits[1]} !== {32'd2, 1'b1}) begin n_fail++;
            $display("FAIL sw_lat: got lat=%0d first_we=%b want 2/1", lat, we_bits[1]); end
        preload(32'h44332211, 32'h88776655, 32'h0, 1'b0);
        do_req(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, rd, er, lat, nwe, br, ra, ry);
`ifdef LSU_MISALIGN_EN
        n_cmp++; if ({mem[1], mem[2]} !== {32'hBEEF6655, 32'h0000DEAD}) begin n_fail++;
            $display("FAIL sw_span_mem: got %h %h want beef6655 0000dead", mem[1], mem[2]); end
        n_cmp++; if ({lat, nwe, we_bits[3], we_bits[4]} !== {32'd5, 32'd2, 2'b11}) begin n_fail++;
            $display("FAIL sw_span_timing: got lat=%0d we=%0d want 5/2 consecutive", lat, nwe); end
`else
        n_cmp++; if ({er, lat, nwe} !== {1'b1, 32'd1, 32'd0}) begin n_fail++;
            $display("FAIL sw_mis: got err=%b lat=%0d we=%0d want 1/1/0", er, lat, nwe); end
        n_cmp++; if ({mem[1], mem[2]} !== {32'h88776655, 32'h0}) begin n_fail++;
            $display("FAIL sw_mis_mem: got %h %h want 88776655 0", mem[1], mem[2]); end
`endif
    endtask

    task automatic test_errors();
        bit          wtab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  mtab [4] = '{3'b011, 3'b100, 3'b010, 3'b010};
        logic [31:0] atab [4] = '{32'h0, 32'h0, 32'h400, 32'h3FD};
        logic [31:0] rd; logic er, ra, ry; int lat, nwe, br;
        preload(32'h44332211, 32'h88776655, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_req(wtab[i], mtab[i], atab[i], 32'hCAFEF00D, rd, er, lat, nwe, br, ra, ry);
            n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL err_resp[%0d]: got err=%b data=%h want 1/0", i, er, rd); end
            n_cmp++; if ({lat, nwe} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL err_lat_we[%0d]: got %0d/%0d want 1/0", i, lat, nwe); end
        end
        n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL err_mem: got %0d words differ want 0", mem_diff()); end
    endtask

    task automatic test_random();
        logic [2:0] mtab [13] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001,
                                  3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        logic [31:0] rd, a, wd, exp_rd; logic [2:0] m; logic er, ra, ry; bit we, e, span;
        int lat, nwe, br, sz, off, exp_lat, exp_nwe, r;
        preload($urandom, $urandom, $urandom, 1'b1);
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            m  = mtab[$urandom_range(0, 12)];
            r  = int'($urandom_range(0, 9));
            a  = (r == 0) ? $urandom : (r == 1) ? 32'h3F8 + $urandom_range(0, 7) : $urandom_range(0, NW*4-1);
            wd = $urandom;
            e    = ref_err(we, m, a);
            sz   = size_of(m);
            off  = int'(a % 4);
            span = (off + sz) > 4;
            exp_rd  = (e || we) ? 32'h0 : ref_load(m, a);
            exp_lat = e ? 1 : !we ? (span ? 3 : 2) : (m == 3'b010 && off == 0) ? 2 : (span ? 5 : 3);
            exp_nwe = (e || !we) ? 0 : (span ? 2 : 1);
            if (!e && we) ref_store(a, sz, wd);
            do_req(we, m, a, wd, rd, er, lat, nwe, br, ra, ry);
            n_cmp++; if ({er, rd} !== {e, exp_rd}) begin n_fail++;
                $display("FAIL rnd_resp[%0d] we=%b m=%b a=%h: got %b/%h want %b/%h", t, we, m, a, er, rd, e, exp_rd); end
            n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", t, lat, exp_lat); end
            n_cmp++; if (nwe !== exp_nwe) begin n_fail++; $display("FAIL rnd_we[%0d]: got %0d want %0d", t, nwe, exp_nwe); end
            n_cmp++; if ({br, ra, ry} !== {32'd0, 1'b0, 1'b1}) begin n_fail++;
                $display("FAIL rnd_handshake[%0d]: got busy_rdy=%0d resp_after=%b rdy_after=%b want 0/0/1", t, br, ra, ry); end
            n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL rnd_mem[%0d]: got %0d words differ want 0", t, mem_diff()); end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er, ra, ry; int lat, nwe, br;
        preload(32'h44332211, 32'h88776655, 32'h0, 1'b0);
        @(negedge clk);
`ifdef LSU_MISALIGN_EN
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b010; req_addr = 32'h6; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if ({mem_we, mem_wa} !== {1'b1, 8'd2}) begin n_fail++;
            $display("FAIL midop_in_wr1: got we=%b wa=%0d want 1/2", mem_we, mem_wa); end
        ref_store(32'h6, 2, 32'h0000BEEF);
`else
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b000; req_addr = 32'h5; req_wdata = 32'h000000AB;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_cmp++; if (mem_ra !== 8'd1) begin n_fail++; $display("FAIL midop_in_rd0: got ra=%0d want 1", mem_ra); end
`endif
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_ra, mem_wa, mem_wd} !== '0) begin n_fail++;
            $display("FAIL midop_outputs: got %h want 0", {req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_ra, mem_wa, mem_wd}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready: got %b want 1", req_ready); end
        n_cmp++; if (mem_diff() !== 0) begin n_fail++;
            $display("FAIL midop_mem: got %h %h want %h%h%h%h %h%h%h%h", mem[1], mem[2],
                     ref_bytes[7], ref_bytes[6], ref_bytes[5], ref_bytes[4],
                     ref_bytes[11], ref_bytes[10], ref_bytes[9], ref_bytes[8]); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, nwe, br, ra, ry);
        n_cmp++; if ({er, rd, lat} !== {1'b0, 32'h44332211, 32'd2}) begin n_fail++;
            $display("FAIL midop_next_lw: got err=%b data=%h lat=%0d want 0/44332211/2", er, rd, lat); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
